// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter: the lock FSM state
// enum and a one-hot round-robin pick function sized for up to 16 requesters.
package fifo_wr_arbiter_pkg;

    localparam int MAX_REQ   = 16;
    localparam int MAX_REQ_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Search upward from last+1, wrapping at n_req-1 -> 0; result is one-hot or zero.
    function automatic logic [MAX_REQ-1:0] rr_pick_onehot(
        input logic [MAX_REQ-1:0]   reqs,
        input logic [MAX_REQ_W-1:0] last,
        input int                   n_req
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last) + k) % n_req;
            if ((k <= n_req) && !found && reqs[idx[MAX_REQ_W-1:0]]) begin
                pick[idx[MAX_REQ_W-1:0]] = 1'b1;
                found                    = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_single_clock_ram.sv
// Single-clock FIFO on an inferred RAM array with registered read; the
// natural downstream consumer of fifo_wr_arbiter. o_overflow is a sticky flag.
module fifo_single_clock_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    output logic                     o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_overflow;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign o_full     = (r_count == DEPTH_L);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_overflow = r_overflow;
    assign w_wr_ok    = i_wr_en && !o_full;
    assign w_rd_ok    = i_rd_en && !o_empty;

    // Array and read register stay reset-free so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
        if (w_rd_ok) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (i_wr_en && o_full) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging N_REQ write requesters into one FIFO write port.
// Define FIFO_WR_ARBITER_LOCK_EN to add req_last and hold the grant for whole packets.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
`ifdef FIFO_WR_ARBITER_LOCK_EN
    input  logic [N_REQ-1:0]          req_last,
`endif
    output logic [N_REQ-1:0]          ack,
    input  logic [$clog2(DEPTH):0]    fifo_cnt,
    output logic                      w_req,
    output logic [DATA_W-1:0]         w_data,
    output logic [$clog2(N_REQ)-1:0]  w_owner
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OWN_W = $clog2(N_REQ);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [DATA_W-1:0]    w_data_arr [N_REQ];
    logic [MAX_REQ-1:0]   w_req_ext;
    logic [MAX_REQ_W-1:0] w_last_ext;
    logic [MAX_REQ-1:0]   w_rr_pick;
    logic [N_REQ-1:0]     w_cand;
    logic                 w_cand_any;
    logic [CNT_W:0]       w_used;
    logic                 w_space;
    logic                 w_grant;
    logic [OWN_W-1:0]     w_win_idx;

    logic                 r_wr_valid;
    logic [DATA_W-1:0]    r_wr_data;
    logic [OWN_W-1:0]     r_wr_owner;
    logic [OWN_W-1:0]     r_last_winner;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[N_REQ-1:0]   = req;
        w_last_ext             = '0;
        w_last_ext[OWN_W-1:0]  = r_last_winner;
        w_rr_pick              = rr_pick_onehot(w_req_ext, w_last_ext, N_REQ);
    end

    // The word registered last cycle is not yet in fifo_cnt, so count it as used.
    assign w_used  = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, r_wr_valid};
    assign w_space = (w_used < DEPTH_L);

`ifdef FIFO_WR_ARBITER_LOCK_EN
    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [N_REQ-1:0] w_owner_mask;

    always_comb begin
        w_owner_mask                = '0;
        w_owner_mask[r_last_winner] = 1'b1;
    end

    // While a packet is open, only its owner may win, so it is the last winner.
    assign w_cand     = (r_state == LOCKED) ? (req & w_owner_mask) : w_rr_pick[N_REQ-1:0];
    assign w_cand_any = (r_state == LOCKED) ? (|w_cand) : (|w_rr_pick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant && !req_last[w_win_idx]) begin
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (w_grant && req_last[w_win_idx]) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end
`else
    assign w_cand     = w_rr_pick[N_REQ-1:0];
    assign w_cand_any = |w_rr_pick;
`endif

    assign w_grant = w_space && w_cand_any && !rst;
    assign ack     = w_grant ? w_cand : '0;

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_cand[i]) begin
                w_win_idx = OWN_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_valid    <= 1'b0;
            r_wr_data     <= '0;
            r_wr_owner    <= '0;
            r_last_winner <= OWN_W'(N_REQ - 1);
        end else begin
            r_wr_valid <= w_grant;
            if (w_grant) begin
                r_wr_data     <= w_data_arr[w_win_idx];
                r_wr_owner    <= w_win_idx;
                r_last_winner <= w_win_idx;
            end
        end
    end

    assign w_req   = r_wr_valid;
    assign w_data  = r_wr_data;
    assign w_owner = r_wr_owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter driving a fifo_single_clock_ram;
// a behavioural model predicts acks and the expected write stream.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int OW    = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [CW-1:0]   fifo_cnt;
    logic [CW-1:0]   tb_cnt;
    logic [CW-1:0]   ram_count;
    logic            w_req;
    logic [DW-1:0]   w_data;
    logic [OW-1:0]   w_owner;
    logic            use_fifo;
    logic            rd_en;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            ram_full;
    logic            ram_empty;
    logic            ram_ovf;
    int              rd_pct;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] fifo_q[$];

    int m_last;
    bit m_wreq;
    bit m_locked;
    int n_cmp;
    int n_err;

    always #5 clk = ~clk;

    assign fifo_cnt = use_fifo ? ram_count : tb_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef FIFO_WR_ARBITER_LOCK_EN
        .req_last (req_last),
`endif
        .ack      (ack),
        .fifo_cnt (fifo_cnt),
        .w_req    (w_req),
        .w_data   (w_data),
        .w_owner  (w_owner)
    );

    fifo_single_clock_ram #(.DATA_W(DW), .DEPTH(DEPTH)) u_ram (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_req & use_fifo),
        .i_wr_data  (w_data),
        .i_rd_en    (rd_en),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_count    (ram_count),
        .o_full     (ram_full),
        .o_empty    (ram_empty),
        .o_overflow (ram_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: open packet keeps its owner, else first active above last winner.
    function automatic int model_pick(input logic [N-1:0] r);
        if (m_locked) return r[m_last] ? m_last : -1;
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last   = N - 1;
        m_wreq   = 1'b0;
        m_locked = 1'b0;
        sb_q.delete();
        fifo_q.delete();
    endtask

    // One clock: drive at negedge, check ack before posedge, advance the model at posedge.
    task automatic step(input logic [N-1:0] r, input logic [N*DW-1:0] d,
                        input logic [N-1:0] l, input int cnt, output int win);
        int free;
        int used;
        req      = r;
        req_data = d;
        req_last = l;
        tb_cnt   = CW'(cnt);
        #1;
        used = use_fifo ? int'(ram_count) : cnt;
        free = DEPTH - used - int'(m_wreq);
        win  = (free > 0) ? model_pick(r) : -1;
        chk("ack", {60'd0, ack}, (win >= 0) ? (64'd1 << win) : 64'd0);
        chk("w_req_level", {63'd0, w_req}, {63'd0, m_wreq});
        if (win >= 0) begin
            sb_q.push_back('{win, d[win*DW +: DW]});
            if (use_fifo) fifo_q.push_back(d[win*DW +: DW]);
            $display("txn: grant req=%0d data=%h free=%0d", win, d[win*DW +: DW], free);
        end
        @(posedge clk);
        m_wreq = (win >= 0);
        if (win >= 0) begin
`ifdef FIFO_WR_ARBITER_LOCK_EN
            if (!m_locked && !l[win]) m_locked = 1'b1;
            else if (m_locked && l[win]) m_locked = 1'b0;
`endif
            m_last = win;
        end
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (w_req === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("w_req_spurious", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("w_owner", {62'd0, w_owner}, 64'(e.owner));
                    chk("w_data", {48'd0, w_data}, {48'd0, e.data});
                end
            end
        end
    end

    initial begin : fifo_reader
        forever begin
            @(posedge clk);
            #1;
            if (rd_valid === 1'b1 && use_fifo) begin
                if (fifo_q.size() == 0) begin
                    chk("fifo_read_spurious", 64'd1, 64'd0);
                end else begin
                    chk("fifo_rd_data", {48'd0, rd_data}, {48'd0, fifo_q.pop_front()});
                end
            end
        end
    end

    initial begin : read_driver
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = use_fifo && ($urandom_range(1, 100) <= rd_pct);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    logic [N-1:0]    r_v;
    logic [N-1:0]    l_v;
    logic [N*DW-1:0] d_v;
    int              win;
    bit              keep;

    initial begin : main
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; req = '0; req_data = '0; req_last = '0; tb_cnt = '0;
        use_fifo = 1'b0; rd_pct = 0;
        model_reset();
        repeat (2) @(negedge clk);
        req = '1;
        #1;
        chk("reset_ack", {60'd0, ack}, 64'd0);
        chk("reset_w_req", {63'd0, w_req}, 64'd0);
        chk("reset_w_owner", {62'd0, w_owner}, 64'd0);
        chk("reset_w_data", {48'd0, w_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full contention with an empty FIFO rotates 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            d_v = {$urandom, $urandom};
            step(4'b1111, d_v, 4'b1111, 0, win);
        end
        step(4'b0000, '0, 4'b0000, 0, win);
        // One free slot: grant, blocked while the pending write lands, then grant again.
        for (int i = 0; i < 3; i++) begin
            d_v = {$urandom, $urandom};
            step(4'b0001, d_v, 4'b1111, 7, win);
        end
        // Full FIFO blocks; round robin resumes above the remembered winner.
        step(4'b0001, {$urandom, $urandom}, 4'b1111, 0, win);
        for (int i = 0; i < 5; i++) step(4'b0110, {$urandom, $urandom}, 4'b1111, 8, win);
        step(4'b0110, {$urandom, $urandom}, 4'b1111, 7, win);
        step(4'b0000, '0, 4'b0000, 0, win);

        // Asynchronous reset while a write is in flight.
        step(4'b0101, {$urandom, $urandom}, 4'b1111, 0, win);
        #2;
        chk("pre_rst_w_req", {63'd0, w_req}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_w_req_drop", {63'd0, w_req}, 64'd0);
        chk("rst_ack", {60'd0, ack}, 64'd0);
        chk("rst_w_data", {48'd0, w_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b1110, {$urandom, $urandom}, 4'b1111, 0, win);
        step(4'b0000, '0, 4'b0000, 0, win);

`ifdef FIFO_WR_ARBITER_LOCK_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(4'b0011, {$urandom, $urandom}, 4'b0000, 0, win);
        step(4'b0011, {$urandom, $urandom}, 4'b0000, 0, win);
        step(4'b0011, {$urandom, $urandom}, 4'b0001, 0, win);
        step(4'b0010, {$urandom, $urandom}, 4'b0010, 0, win);
        step(4'b0000, '0, 4'b0000, 0, win);
`endif

        // Random traffic into the real FIFO with a randomly paced reader.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        use_fifo = 1'b1;
        r_v = '0;
        l_v = '1;
        d_v = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rd_pct = (cyc < 200) ? 30 : (cyc < 400) ? 90 : 60;
            for (int i = 0; i < N; i++) begin
                if (!r_v[i] && ($urandom_range(0, 2) == 0)) begin
                    r_v[i]          = 1'b1;
                    d_v[i*DW +: DW] = DW'($urandom);
                    l_v[i]          = ($urandom_range(0, 2) == 0);
                end
            end
            step(r_v, d_v, l_v, 0, win);
            if (win >= 0) begin
                keep = 1'b0;
`ifdef FIFO_WR_ARBITER_LOCK_EN
                keep = !l_v[win];
`endif
                r_v[win]            = keep ? 1'b1 : 1'($urandom_range(0, 1));
                d_v[win*DW +: DW]   = DW'($urandom);
                l_v[win]            = ($urandom_range(0, 2) == 0);
            end
        end
        rd_pct = 100;
        for (int i = 0; i < 2 * DEPTH + 4; i++) step(4'b0000, '0, 4'b0000, 0, win);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("fifo_no_overflow", {63'd0, ram_ovf}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
